seq_match_trigger: RTL and testbench
====================================

SEQ_MATCH_TRIGGER -- requirements
Module: seq_match_trigger

Interface
REQ-001 The module SHALL have parameter DATA_W, default 128, giving the width of the observed data bus.
REQ-002 The module SHALL have parameter DEPTH, default 4, legal 1..8, giving the number of patterns in the trigger sequence.
REQ-003 The module SHALL have parameter PATTERNS, default all zero, width DEPTH*DATA_W, holding pattern k in bits [k*DATA_W +: DATA_W].
REQ-004 The module SHALL have parameter MASK, default all ones, width DATA_W; only bits set in MASK take part in any comparison.
REQ-005 The module SHALL have parameter TIMEOUT, default 16, legal 1..65535, giving the maximum number of cycles allowed between consecutive matches.
REQ-006 The module SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 The module SHALL have port clr, input, 1 bit: synchronous clear of the fired state and the sequence progress.
REQ-009 The module SHALL have port in_valid, input, 1 bit: in_data is sampled only when in_valid is high.
REQ-010 The module SHALL have port in_data, input, DATA_W bits: observed data word, for example the cipher state.
REQ-011 The module SHALL have port trig, output, 1 bit: sticky trigger.
REQ-012 The module SHALL have port trig_pulse, output, 1 bit: single-cycle strobe, high in the first cycle trig is high.
REQ-013 The module SHALL have port stage, output, $clog2(DEPTH+1) bits: number of patterns matched so far.

Function
REQ-014 The module SHALL define a beat as "matching pattern k" when (in_data & MASK) == (PATTERNS[k] & MASK) and in_valid is 1.
REQ-015 The FSM SHALL have states IDLE (stage=0), TRACK (0<stage<DEPTH) and FIRED (stage=DEPTH).
REQ-016 In IDLE or TRACK, a beat matching pattern[stage] SHALL increment stage at the next edge.
REQ-017 In TRACK, a valid beat that does not match pattern[stage] but matches pattern[0] SHALL set stage to 1; any other non-matching valid beat SHALL set stage to 0.
REQ-018 A cycle with in_valid low SHALL leave stage unchanged, apart from the timeout rule.
REQ-019 The beat that matches pattern[DEPTH-1] SHALL move the FSM to FIRED; trig and trig_pulse SHALL be high starting on the next cycle, giving a latency of 1 cycle.
REQ-020 With DEPTH=1, the FSM SHALL go from IDLE straight to FIRED on a single match.
REQ-021 In FIRED, trig SHALL stay at 1 and in_data SHALL be ignored until clr or rst is asserted.
REQ-022 When clr is high, the FSM SHALL go to IDLE and trig SHALL be 0 from the next cycle; clr SHALL win over a final match in the same cycle.
REQ-023 The stage output SHALL equal the registered stage value, so that stage=DEPTH exactly when trig=1.

Reset
REQ-024 When rst is high at an edge, the module SHALL set state=IDLE, stage=0, trig=0, trig_pulse=0 and the timeout counter to 0.
REQ-025 rst SHALL take priority over clr and in_valid; a sequence in progress SHALL be abandoned and not resumed.

Configuration
REQ-026 When macro SEQ_TRIG_TIMEOUT_EN is defined, a 16-bit counter SHALL count cycles in TRACK since the last match, and SHALL be cleared by every match and on every entry to TRACK.
REQ-027 With SEQ_TRIG_TIMEOUT_EN defined, when the counter reaches TIMEOUT-1 and there is no match that cycle, stage SHALL return to 0 at that edge; a match in that same cycle SHALL win.
REQ-028 Without SEQ_TRIG_TIMEOUT_EN, the module SHALL contain no counter, the TIMEOUT parameter SHALL be ignored, and progress SHALL be held indefinitely.

Structure
REQ-029 Package seq_trig_pkg SHALL hold the FSM state enum (IDLE, TRACK, FIRED), the MAX_DEPTH=8 constant and the timeout counter width (16).
REQ-030 Sub-module masked_cmp SHALL perform one masked DATA_W-bit equality compare; the top level SHALL instantiate it twice, once for pattern[stage] and once for pattern[0].

Verification
All scenarios use DATA_W=128, DEPTH=2, P0=00112233_44556677_8899aabb_ccddeeff, P1=ffeeddcc_bbaa9988_77665544_33221100, MASK all ones and TIMEOUT=4.
REQ-031 In-order sequence: valid P0 then valid P1 on consecutive cycles -> stage goes 1 then 2; trig rises 1 cycle after P1; trig_pulse is high for exactly 1 cycle.
REQ-032 Restart on repeat: beats P0, P0, P1 -> stage goes 1, 1, 2 and trig fires; beats P0, 0, P1 -> stage goes 1, 0, 0 and trig stays 0.
REQ-033 Gaps: P0, then 3 idle cycles, then P1 with the macro defined -> trig fires; P0, then 4 idle cycles, then P1 -> stage returns to 0 after the 4th idle cycle and trig stays 0; without the macro, P0, 100 idle cycles, P1 -> trig fires.
REQ-034 Clear precedence: clr held high in the same cycle as the P1 beat -> trig stays 0 and stage=0; with trig=1 and clr pulsed -> trig=0 on the next cycle.
REQ-035 Mid-sequence reset: rst asserted after P0 -> stage=0; a following lone P1 -> no trigger.
REQ-036 Mask: with MASK=128'hFFFF...FF00, the sequence P0 with low byte 00, then P1 -> trig fires.

Source files
------------

// File: rtl/seq_match_trigger_pkg.sv
// Shared types and constants for the sequence-match trigger.
// Holds the FSM state encoding, the largest supported sequence depth
// and the width of the optional inter-match timeout counter.
package seq_trig_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FIRED = 2'd2
  } state_e;

  localparam int MAX_DEPTH = 8;
  localparam int TO_CNT_W  = 16;

endpackage

// File: rtl/seq_match_trigger_masked_cmp.sv
// Masked equality compare of one observed word against one pattern.
// Only bits set in MASK participate; all other bits are don't-care.
module masked_cmp #(
  parameter int              DATA_W = 128,
  parameter logic [DATA_W-1:0] MASK = '1
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] pattern,
  output logic              eq
);

  // Equal when no masked-in bit differs.
  always_comb begin
    eq = ((data ^ pattern) & MASK) == '0;
  end

endmodule

// File: rtl/seq_match_trigger.sv
// Sticky trigger that fires once DEPTH patterns have been observed in order
// on the valid beats of in_data (e.g. to catch a cipher state sequence).
// Optional feature: define SEQ_TRIG_TIMEOUT_EN to abandon a partial sequence
// when more than TIMEOUT cycles pass between consecutive matches.
module seq_match_trigger
  import seq_trig_pkg::*;
#(
  parameter int                      DATA_W   = 128,
  parameter int                      DEPTH    = 4,
  parameter logic [DEPTH*DATA_W-1:0] PATTERNS = '0,
  parameter logic [DATA_W-1:0]       MASK     = '1,
  parameter int                      TIMEOUT  = 16,
  localparam int                     STAGE_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               trig,
  output logic               trig_pulse,
  output logic [STAGE_W-1:0] stage
);

  localparam logic [STAGE_W-1:0] DEPTH_S = STAGE_W'(DEPTH);

  state_e             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic               trig_q, trig_d;
  logic               pulse_q, pulse_d;

  logic [DATA_W-1:0]  cur_pattern;
  logic [STAGE_W-1:0] stage_inc;
  logic               eq_cur, eq_zero;
  logic               hit_cur, hit_zero;
  logic               timeout_hit;

  // Select the pattern the sequence is waiting for; FIRED falls back to pattern 0.
  always_comb begin
    cur_pattern = PATTERNS[DATA_W-1:0];
    for (int k = 0; k < DEPTH; k++) begin
      if (stage_q == STAGE_W'(k)) begin
        cur_pattern = PATTERNS[k*DATA_W +: DATA_W];
      end
    end
  end

  masked_cmp #(.DATA_W(DATA_W), .MASK(MASK)) u_cmp_cur (
    .data    (in_data),
    .pattern (cur_pattern),
    .eq      (eq_cur)
  );

  masked_cmp #(.DATA_W(DATA_W), .MASK(MASK)) u_cmp_zero (
    .data    (in_data),
    .pattern (PATTERNS[DATA_W-1:0]),
    .eq      (eq_zero)
  );

  assign hit_cur   = in_valid & eq_cur;
  assign hit_zero  = in_valid & eq_zero;
  assign stage_inc = stage_q + 1'b1;

`ifdef SEQ_TRIG_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == TO_LAST);

  // Counter of cycles spent in TRACK since the most recent match.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || state_q != TRACK || hit_cur || in_valid) begin
      cnt_d = '0;
    end else if (!timeout_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Sequence tracking: advance on a match, restart or drop on a miss, hold when fired.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    if (clr) begin
      state_d = IDLE;
      stage_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_cur) begin
            stage_d = stage_inc;
            state_d = (DEPTH == 1) ? FIRED : TRACK;
          end
        end
        TRACK: begin
          if (hit_cur) begin
            stage_d = stage_inc;
            if (stage_inc == DEPTH_S) state_d = FIRED;
          end else if (in_valid) begin
            if (hit_zero) begin
              stage_d = STAGE_W'(1);
            end else begin
              stage_d = '0;
              state_d = IDLE;
            end
          end else if (timeout_hit) begin
            stage_d = '0;
            state_d = IDLE;
          end
        end
        FIRED: begin
          state_d = FIRED;
        end
        default: begin
          state_d = IDLE;
          stage_d = '0;
        end
      endcase
    end
    trig_d  = (state_d == FIRED);
    pulse_d = (state_d == FIRED) && (state_q != FIRED);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      trig_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      trig_q  <= trig_d;
      pulse_q <= pulse_d;
    end
  end

  assign trig       = trig_q;
  assign trig_pulse = pulse_q;
  assign stage      = stage_q;

endmodule

// File: tb/tb_seq_match_trigger.sv
// Self-checking bench for seq_match_trigger (DEPTH=2, TIMEOUT=4).
// Expected {stage, trig, trig_pulse} values are queued as each beat is driven
// and popped after the following rising edge. A second instance covers MASK.
module tb_seq_match_trigger;

  localparam logic [127:0] P0 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] P1 = 128'hffeeddcc_bbaa9988_77665544_33221100;
  localparam logic [127:0] P0_LOW0 = 128'h00112233_44556677_8899aabb_ccddee00;
  localparam logic [127:0] MASK_HI = {{120{1'b1}}, 8'h00};

  typedef struct packed {
    logic         r;
    logic         c;
    logic         v;
    logic [127:0] d;
    logic [3:0]   e;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1, clr = 1'b0, in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         trig, trig_pulse;
  logic [1:0]   stage;

  logic         m_rst = 1'b1, m_clr = 1'b0, m_valid = 1'b0;
  logic [127:0] m_data = '0;
  logic         m_trig, m_pulse;
  logic [1:0]   m_stage;

  logic [3:0]   exp_q[$];
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  seq_match_trigger #(
    .DATA_W(128), .DEPTH(2), .PATTERNS({P1, P0}), .MASK('1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .trig(trig), .trig_pulse(trig_pulse), .stage(stage)
  );

  seq_match_trigger #(
    .DATA_W(128), .DEPTH(2), .PATTERNS({P1, P0}), .MASK(MASK_HI), .TIMEOUT(4)
  ) dut_m (
    .clk(clk), .rst(m_rst), .clr(m_clr), .in_valid(m_valid), .in_data(m_data),
    .trig(m_trig), .trig_pulse(m_pulse), .stage(m_stage)
  );

  function automatic beat_t mk(input logic r, input logic c, input logic v,
                               input logic [127:0] d, input logic [1:0] st,
                               input logic tr, input logic pu);
    beat_t b;
    b.r = r; b.c = c; b.v = v; b.d = d; b.e = {st, tr, pu};
    return b;
  endfunction

  // Drive one beat on the chosen instance, queue its expectation, step past the edge.
  task automatic drive(input beat_t b, input bit on_mask);
    @(negedge clk);
    if (on_mask) begin
      m_rst = b.r; m_clr = b.c; m_valid = b.v; m_data = b.d;
    end else begin
      rst = b.r; clr = b.c; in_valid = b.v; in_data = b.d;
    end
    exp_q.push_back(b.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    beat_t seq[$];
    logic [3:0] expv;
    seq.push_back(mk(1, 0, 1, P0, 2'd0, 0, 0));
    seq.push_back(mk(1, 1, 1, P1, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 0, '0, 2'd0, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i], 0);
      expv = exp_q.pop_front();
      total++;
      if ({stage, trig, trig_pulse} !== expv) begin
        bad++;
        $display("FAIL reset beat %0d: got %b want %b", i, {stage, trig, trig_pulse}, expv);
      end
    end
  endtask

  task automatic test_in_order;
    beat_t seq[$];
    logic [3:0] expv;
    seq.push_back(mk(0, 0, 1, P1, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 1, P0, 2'd1, 0, 0));
    seq.push_back(mk(0, 0, 1, P1, 2'd2, 1, 1));
    seq.push_back(mk(0, 0, 0, '0, 2'd2, 1, 0));
    seq.push_back(mk(0, 0, 1, P0, 2'd2, 1, 0));
    seq.push_back(mk(0, 0, 1, P1, 2'd2, 1, 0));
    seq.push_back(mk(0, 1, 0, '0, 2'd0, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i], 0);
      expv = exp_q.pop_front();
      total++;
      if ({stage, trig, trig_pulse} !== expv) begin
        bad++;
        $display("FAIL in_order beat %0d: got %b want %b", i, {stage, trig, trig_pulse}, expv);
      end
    end
  endtask

  task automatic test_restart;
    beat_t seq[$];
    logic [3:0] expv;
    seq.push_back(mk(0, 0, 1, P0, 2'd1, 0, 0));
    seq.push_back(mk(0, 0, 1, P0, 2'd1, 0, 0));
    seq.push_back(mk(0, 0, 1, P1, 2'd2, 1, 1));
    seq.push_back(mk(0, 1, 0, '0, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 1, P0, 2'd1, 0, 0));
    seq.push_back(mk(0, 0, 1, '0, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 1, P1, 2'd0, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i], 0);
      expv = exp_q.pop_front();
      total++;
      if ({stage, trig, trig_pulse} !== expv) begin
        bad++;
        $display("FAIL restart beat %0d: got %b want %b", i, {stage, trig, trig_pulse}, expv);
      end
    end
  endtask

  task automatic test_gaps;
    beat_t seq[$];
    logic [3:0] expv;
`ifdef SEQ_TRIG_TIMEOUT_EN
    seq.push_back(mk(0, 0, 1, P0, 2'd1, 0, 0));
    for (int k = 0; k < 3; k++) seq.push_back(mk(0, 0, 0, P1, 2'd1, 0, 0));
    seq.push_back(mk(0, 0, 1, P1, 2'd2, 1, 1));
    seq.push_back(mk(0, 1, 0, '0, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 1, P0, 2'd1, 0, 0));
    for (int k = 0; k < 3; k++) seq.push_back(mk(0, 0, 0, '0, 2'd1, 0, 0));
    seq.push_back(mk(0, 0, 0, '0, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 1, P1, 2'd0, 0, 0));
`else
    seq.push_back(mk(0, 0, 1, P0, 2'd1, 0, 0));
    for (int k = 0; k < 100; k++) seq.push_back(mk(0, 0, 0, P1, 2'd1, 0, 0));
    seq.push_back(mk(0, 0, 1, P1, 2'd2, 1, 1));
    seq.push_back(mk(0, 1, 0, '0, 2'd0, 0, 0));
`endif
    foreach (seq[i]) begin
      drive(seq[i], 0);
      expv = exp_q.pop_front();
      total++;
      if ({stage, trig, trig_pulse} !== expv) begin
        bad++;
        $display("FAIL gaps beat %0d: got %b want %b", i, {stage, trig, trig_pulse}, expv);
      end
    end
  endtask

  task automatic test_clear;
    beat_t seq[$];
    logic [3:0] expv;
    seq.push_back(mk(0, 0, 1, P0, 2'd1, 0, 0));
    seq.push_back(mk(0, 1, 1, P1, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 0, '0, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 1, P0, 2'd1, 0, 0));
    seq.push_back(mk(0, 0, 1, P1, 2'd2, 1, 1));
    seq.push_back(mk(0, 1, 0, '0, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 1, P1, 2'd0, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i], 0);
      expv = exp_q.pop_front();
      total++;
      if ({stage, trig, trig_pulse} !== expv) begin
        bad++;
        $display("FAIL clear beat %0d: got %b want %b", i, {stage, trig, trig_pulse}, expv);
      end
    end
  endtask

  task automatic test_mid_reset;
    beat_t seq[$];
    logic [3:0] expv;
    seq.push_back(mk(0, 0, 1, P0, 2'd1, 0, 0));
    seq.push_back(mk(1, 0, 1, P1, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 1, P1, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 0, '0, 2'd0, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i], 0);
      expv = exp_q.pop_front();
      total++;
      if ({stage, trig, trig_pulse} !== expv) begin
        bad++;
        $display("FAIL mid_reset beat %0d: got %b want %b", i, {stage, trig, trig_pulse}, expv);
      end
    end
  endtask

  task automatic test_mask;
    beat_t seq[$];
    logic [3:0] expv;
    seq.push_back(mk(1, 0, 0, '0, 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 1, P0 ^ (128'd1 << 64), 2'd0, 0, 0));
    seq.push_back(mk(0, 0, 1, P0_LOW0, 2'd1, 0, 0));
    seq.push_back(mk(0, 0, 1, P1 | 128'hff, 2'd2, 1, 1));
    seq.push_back(mk(0, 0, 0, '0, 2'd2, 1, 0));
    foreach (seq[i]) begin
      drive(seq[i], 1);
      expv = exp_q.pop_front();
      total++;
      if ({m_stage, m_trig, m_pulse} !== expv) begin
        bad++;
        $display("FAIL mask beat %0d: got %b want %b", i, {m_stage, m_trig, m_pulse}, expv);
      end
    end
  endtask

  initial begin
    test_reset;
    test_in_order;
    test_restart;
    test_gaps;
    test_clear;
    test_mid_reset;
    test_mask;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
